// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter.
// Bus writes (i_iocs && i_iorw) are queued in a small FIFO; each entry is
// sent as start, DATA_W data bits LSB first, optional parity, 1..2 stop bits.
// Every bit lasts OVERSAMPLE b_en pulses. o_tx is a registered decode of the
// FSM state, so the line follows a state change by one clk.
// Optional build macro: UART_TX_BREAK_EN enables break generation on i_break.
module uart_tx_fifo #(
  parameter int DATA_W      = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              b_en,
  input  logic              i_iocs,
  input  logic              i_iorw,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_break,
  output logic              o_tx,
  output logic              o_tbr,
  output logic              o_busy,
  output logic              o_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE-1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W-1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          PAR_ODD   = (PARITY_MODE == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [SW-1:0]     samp;
  logic [BW-1:0]     bit_cnt;
  logic              stop_cnt;
  logic [DATA_W-1:0] shift;
  logic              par;
  logic              line;
  logic              brk;
  logic              pop_ok;

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, count;
  logic [DATA_W-1:0] head;
  logic              wr_req, wr_acc, pop, empty, full, frame_end;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign o_tbr     = !full;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign wr_req    = i_iocs && i_iorw;
  // last b_en of the last stop bit: a waiting entry goes straight to START
  assign frame_end = (state == STOP) && (samp == SAMP_LAST) && (stop_cnt == STOP_LAST);
  assign pop       = b_en && !empty && pop_ok && ((state == IDLE) || frame_end);
  // a pop in the same cycle frees a slot, so a full FIFO can still accept
  assign wr_acc    = wr_req && (!full || pop);
  assign o_busy    = (state != IDLE) || !empty || brk;

  // storage; no reset needed, validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  // pointer update and dropped-write pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_ovf  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      o_ovf <= wr_req && !wr_acc;
    end
  end

  // ---------------- frame FSM, advances only on b_en ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      samp     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      par      <= 1'b0;
    end else if (b_en) begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= head;
            par   <= (^head) ^ PAR_ODD;
            samp  <= '0;
            state <= START;
          end
        end
        START: begin
          if (samp == SAMP_LAST) begin
            samp    <= '0;
            bit_cnt <= '0;
            state   <= DATA;
          end else samp <= samp + 1'b1;
        end
        DATA: begin
          if (samp == SAMP_LAST) begin
            samp    <= '0;
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              stop_cnt <= 1'b0;
              state    <= (PARITY_MODE != 0) ? PARITY : STOP;
            end
          end else samp <= samp + 1'b1;
        end
        PARITY: begin
          if (samp == SAMP_LAST) begin
            samp     <= '0;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end else samp <= samp + 1'b1;
        end
        STOP: begin
          if (samp == SAMP_LAST) begin
            samp <= '0;
            if (stop_cnt == STOP_LAST) begin
              if (pop) begin
                shift <= head;
                par   <= (^head) ^ PAR_ODD;
                state <= START;
              end else state <= IDLE;
            end else stop_cnt <= 1'b1;
          end else samp <= samp + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // line level implied by the current state
  always_comb begin
    line = 1'b1;
    case (state)
      START:   line = 1'b0;
      DATA:    line = shift[0];
      PARITY:  line = par;
      default: line = 1'b1;
    endcase
  end

  // registered TX pin; break forces space
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_tx <= 1'b1;
    else      o_tx <= brk ? 1'b0 : line;
  end

`ifdef UART_TX_BREAK_EN
  localparam int MARK = STOP_BITS * OVERSAMPLE;
  localparam int MW   = $clog2(MARK);
  localparam logic [MW-1:0] MARK_LAST = MW'(MARK-1);

  logic          guard;
  logic [MW-1:0] mark_cnt;

  assign brk    = i_break;
  assign pop_ok = !i_break && !guard;

  // after break, hold off pops until a full stop period of idle mark has passed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      guard    <= 1'b0;
      mark_cnt <= '0;
    end else if (i_break) begin
      guard    <= 1'b1;
      mark_cnt <= '0;
    end else if (guard && b_en && (state == IDLE)) begin
      if (mark_cnt == MARK_LAST) guard <= 1'b0;
      else                       mark_cnt <= mark_cnt + 1'b1;
    end
  end
`else
  logic unused_brk;
  assign unused_brk = i_break;
  assign brk        = 1'b0;
  assign pop_ok     = 1'b1;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three transmitters (no parity / even / odd + 2 stop)
// share one stimulus stream; the line of each is predicted from frame
// construction rules and decoded like a UART receiver would.
module tb_uart_tx_fifo;
  localparam int NI = 3;
  localparam int OS = 16;

  logic clk = 1'b0, rst = 1'b1, b_en = 1'b1;
  logic i_iocs = 1'b0, i_iorw = 1'b0, i_break = 1'b0;
  logic [7:0] i_data = '0;
  logic [NI-1:0] tx, tbr, busy, ovf;

  int n_cmp = 0, n_fail = 0, cyc = 0, ben_div = 1;
  int PM[NI] = '{0, 1, 2};
  int SB[NI] = '{1, 1, 2};
  logic [7:0] stream[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.PARITY_MODE(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .b_en(b_en), .i_iocs(i_iocs), .i_iorw(i_iorw),
    .i_data(i_data), .i_break(i_break), .o_tx(tx[0]), .o_tbr(tbr[0]),
    .o_busy(busy[0]), .o_ovf(ovf[0]));
  uart_tx_fifo #(.PARITY_MODE(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .b_en(b_en), .i_iocs(i_iocs), .i_iorw(i_iorw),
    .i_data(i_data), .i_break(i_break), .o_tx(tx[1]), .o_tbr(tbr[1]),
    .o_busy(busy[1]), .o_ovf(ovf[1]));
  uart_tx_fifo #(.PARITY_MODE(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .b_en(b_en), .i_iocs(i_iocs), .i_iorw(i_iorw),
    .i_data(i_data), .i_break(i_break), .o_tx(tx[2]), .o_tbr(tbr[2]),
    .o_busy(busy[2]), .o_ovf(ovf[2]));

  // frame slots LSB first: start, data, parity (if any), stops; ones beyond
  function automatic logic [11:0] frame(input logic [7:0] d, input int pm);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    if (pm == 1) f[9] = ^d;
    else if (pm == 2) f[9] = ~^d;
    return f;
  endfunction

  function automatic int flen(input int i);
    return 1 + 8 + ((PM[i] != 0) ? 1 : 0) + SB[i];
  endfunction

  function automatic logic rand_brk();
`ifdef UART_TX_BREAK_EN
    return 1'b0;
`else
    return 1'($urandom);
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    b_en = (ben_div > 1) ? ((cyc % ben_div) == 0) : 1'b1;
  endtask

  task automatic chk_idle(input string name);
    n_cmp += 4;
    if (tx !== '1)   begin n_fail++; $display("FAIL %s tx got %b want 111", name, tx); end
    if (tbr !== '1)  begin n_fail++; $display("FAIL %s tbr got %b want 111", name, tbr); end
    if (busy !== '0) begin n_fail++; $display("FAIL %s busy got %b want 000", name, busy); end
    if (ovf !== '0)  begin n_fail++; $display("FAIL %s ovf got %b want 000", name, ovf); end
  endtask

  // writes `stream` on consecutive clks with b_en tied high and checks every
  // clk of every instance against the concatenated frames
  task automatic run_stream(input string name);
    int n, kmax, s, L;
    logic [11:0] f;
    logic ex_tx, ex_busy;
    n = stream.size();
    kmax = OS * n * 12 + 4;
    tick();
    i_iocs = 1'b1; i_iorw = 1'b1; i_data = stream[0];
    for (int k = 0; k <= kmax; k++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        L = flen(i);
        ex_tx = 1'b1;
        if (k >= 2) begin
          s = (k - 2) / OS;
          if (s / L < n) begin
            f = frame(stream[s / L], PM[i]);
            ex_tx = f[s % L];
          end
        end
        ex_busy = (k <= OS * n * L);
        n_cmp += 2;
        if (tx[i] !== ex_tx) begin
          n_fail++; $display("FAIL %s tx[%0d] k=%0d got %b want %b", name, i, k, tx[i], ex_tx);
        end
        if (busy[i] !== ex_busy) begin
          n_fail++; $display("FAIL %s busy[%0d] k=%0d got %b want %b", name, i, k, busy[i], ex_busy);
        end
      end
      i_break = rand_brk();
      if (k + 1 < n) i_data = stream[k + 1];
      else begin
        i_iocs = 1'($urandom);
        i_iorw = i_iocs ? 1'b0 : 1'($urandom);
        i_data = 8'($urandom);
      end
    end
    i_iocs = 1'b0; i_iorw = 1'b0; i_break = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    chk_idle("reset_held");
    rst = 1'b1;
    repeat (2) tick();
    chk_idle("reset_released");
  endtask

  task automatic test_frame();
    stream = '{8'hA5};
    run_stream("frame_a5");
  endtask

  task automatic test_parity();
    stream = '{8'h01};
    run_stream("parity_01");
    stream = '{8'h03};
    run_stream("parity_03");
  endtask

  task automatic test_back_to_back();
    stream = '{8'h00, 8'hFF};
    run_stream("b2b_00_ff");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      stream = {};
      for (int j = 0; j < int'($urandom_range(1, 5)); j++) stream.push_back(8'($urandom));
      run_stream($sformatf("random%0d", r));
    end
  endtask

  task automatic test_fifo_ovf();
    logic [7:0] d[6];
    logic [7:0] got;
    logic st, sp, low_seen;
    int t;
    foreach (d[i]) d[i] = 8'($urandom);
    ben_div = 8;
    do tick(); while ((cyc % 8) != 7);
    i_iocs = 1'b1; i_iorw = 1'b1; i_data = d[0];
    for (int p = 0; p < 5; p++) begin
      tick();
      if (p == 3) begin
        n_cmp++;
        if (tbr !== '1) begin n_fail++; $display("FAIL fifo tbr_3 got %b want 111", tbr); end
      end
      if (p == 4) begin
        n_cmp += 2;
        if (tbr !== '0) begin n_fail++; $display("FAIL fifo tbr_full got %b want 000", tbr); end
        if (ovf !== '0) begin n_fail++; $display("FAIL fifo ovf_early got %b want 000", ovf); end
      end
      i_data = d[p + 1];
    end
    tick();
    i_iocs = 1'b0; i_iorw = 1'b0;
    n_cmp += 2;
    if (ovf !== '1) begin n_fail++; $display("FAIL fifo ovf_pulse got %b want 111", ovf); end
    if (tbr !== '0) begin n_fail++; $display("FAIL fifo tbr_after_drop got %b want 000", tbr); end
    tick();
    n_cmp++;
    if (ovf !== '0) begin n_fail++; $display("FAIL fifo ovf_one_cycle got %b want 000", ovf); end
    // receive five frames on the no-parity instance, sampling mid-bit
    for (int f = 0; f < 5; f++) begin
      t = 0;
      while (tx[0] !== 1'b0 && t < 4000) begin tick(); t++; end
      n_cmp++;
      if (t >= 4000) begin
        n_fail++; $display("FAIL fifo start%0d timeout got none want start bit", f);
      end else begin
        repeat (64) tick();
        st = tx[0];
        got = '0;
        for (int b = 0; b < 8; b++) begin repeat (128) tick(); got[b] = tx[0]; end
        repeat (128) tick();
        sp = tx[0];
        n_cmp += 2;
        if (got !== d[f]) begin n_fail++; $display("FAIL fifo byte%0d got %h want %h", f, got, d[f]); end
        if ({st, sp} !== 2'b01) begin
          n_fail++; $display("FAIL fifo framing%0d got start=%b stop=%b want 0/1", f, st, sp);
        end
      end
    end
    t = 0; low_seen = 1'b0;
    while (busy !== '0 && t < 20000) begin tick(); t++; if (tx[0] === 1'b0) low_seen = 1'b1; end
    n_cmp += 2;
    if (busy !== '0) begin n_fail++; $display("FAIL fifo drain got busy=%b want 000", busy); end
    if (low_seen)    begin n_fail++; $display("FAIL fifo sixth_frame got extra start want none"); end
    ben_div = 1;
    tick();
  endtask

  task automatic test_reset_midframe();
    tick();
    i_iocs = 1'b1; i_iorw = 1'b1;
    for (int j = 0; j < 3; j++) begin i_data = 8'($urandom); tick(); end
    i_iocs = 1'b0; i_iorw = 1'b0;
    repeat (60) tick();
    #1 rst = 1'b0;
    #1 chk_idle("reset_async");
    repeat (2) tick();
    chk_idle("reset_mid_held");
    rst = 1'b1;
    tick();
    stream = '{8'h3C};
    run_stream("after_reset_3c");
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int t, ones;
    tick();
    i_iocs = 1'b1; i_iorw = 1'b1; i_data = 8'h55;
    tick(); i_data = 8'hC3;
    tick(); i_iocs = 1'b0; i_iorw = 1'b0;
    repeat (40) tick();
    i_break = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      n_cmp += 2;
      if (tx !== '0)   begin n_fail++; $display("FAIL break tx k=%0d got %b want 000", k, tx); end
      if (busy !== '1) begin n_fail++; $display("FAIL break busy k=%0d got %b want 111", k, busy); end
    end
    i_break = 1'b0;
    ones = 0;
    while (tx[0] === 1'b1 && ones < 2000) begin tick(); ones++; end
    n_cmp += 2;
    if (ones < 16 || ones >= 2000) begin
      n_fail++; $display("FAIL break mark got %0d clks want 16..1999", ones);
    end
    t = 0;
    while (busy !== '0 && t < 5000) begin tick(); t++; end
    if (busy !== '0) begin n_fail++; $display("FAIL break drain got busy=%b want 000", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_parity();
    test_back_to_back();
    test_random();
    test_fifo_ovf();
    test_reset_midframe();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end
endmodule
